// File: rtl/keypad_scanner.sv
// Multiplexed 4x4 key-matrix scanner: rotates a one-cold column strobe, debounces
// all 16 keys over successive scans and queues press/release events in a small FIFO.
module keypad_scanner #(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  rows,
    output logic [3:0]  col_select,
    output logic [3:0]  key_code,
    output logic        key_press,
    output logic        key_valid,
    input  logic        key_ready,
    output logic [15:0] key_state,
    output logic        overflow,
    input  logic        overflow_clr
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    typedef enum logic {
        S_IDLE,
        S_SWEEP
    } sweep_state_t;

    typedef struct packed {
        logic [3:0] code;
        logic       press;
    } key_event_t;

    // ------------------------------------------------------------------
    // Row synchronizer; idle value is all-open so reset never looks like a press.
    // ------------------------------------------------------------------
    logic [3:0] rows_meta;
    logic [3:0] rows_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
        end else begin
            rows_meta <= rows;
            rows_sync <= rows_meta;
        end
    end

    // ------------------------------------------------------------------
    // Column-step divider and strobe rotation
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       col_idx;
    logic [1:0]       eval_col;
    logic [3:0]       sample;

    assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            col_idx  <= 2'd0;
            eval_col <= 2'd0;
            sample   <= 4'hF;
        end else if (tick) begin
            div_cnt  <= '0;
            sample   <= rows_sync;
            eval_col <= col_idx;
            col_idx  <= col_idx + 2'd1;
        end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
        end
    end

    // Rotating the index is equivalent to rotating the one-cold strobe left.
    assign col_select = ~(4'b0001 << col_idx);

    // ------------------------------------------------------------------
    // Evaluation sweep: one row of the sampled column per cycle
    // ------------------------------------------------------------------
    sweep_state_t state_q, state_d;
    logic [1:0]   row_q, row_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                row_d = 2'd0;
                if (tick) state_d = S_SWEEP;
            end
            S_SWEEP: begin
                row_d = row_q + 2'd1;
                if (row_q == 2'd3) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-key debounce
    // ------------------------------------------------------------------
    logic [3:0] cnt [16];
    logic       sweep_active;
    logic [3:0] eval_key;
    logic       raw;
    logic       differs;
    logic [4:0] cnt_next;
    logic       accept;

    assign sweep_active = (state_q == S_SWEEP);
    assign eval_key     = {eval_col, row_q};
    assign raw          = ~sample[row_q];
    assign differs      = (raw != key_state[eval_key]);
    assign cnt_next     = {1'b0, cnt[eval_key]} + 5'd1;
    assign accept       = sweep_active && differs && (cnt_next == 5'(DEBOUNCE_SCANS));

    // NOTE: the counter array is reset explicitly because a mid-debounce reset must
    // not leave partial counts behind; that rules out a reset-less RAM here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state <= '0;
            for (int i = 0; i < 16; i++) cnt[i] <= 4'd0;
        end else if (sweep_active) begin
            if (!differs) begin
                cnt[eval_key] <= 4'd0;
            end else if (accept) begin
                cnt[eval_key]       <= 4'd0;
                key_state[eval_key] <= raw;
            end else begin
                cnt[eval_key] <= cnt_next[3:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO, depth 4, first-word fall-through
    // ------------------------------------------------------------------
    key_event_t fifo_mem [4];
    key_event_t push_data;
    key_event_t head;
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] fifo_count;
    logic       full;
    logic       pop;
    logic       push_ok;
    logic       drop;

    assign push_data = '{code: eval_key, press: raw};
    assign full      = (fifo_count == 3'd4);
    assign key_valid = (fifo_count != 3'd0);
    assign pop       = key_valid && key_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok   = accept && (!full || pop);
    assign drop      = accept && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            fifo_count <= fifo_count + 3'(push_ok) - 3'(pop);
        end
    end

    assign head      = fifo_mem[rd_ptr];
    assign key_code  = head.code;
    assign key_press = head.press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (overflow_clr) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model drives rows from col_select,
// expected events go into a scoreboard queue that a separate monitor drains.
module tb_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rows;
    logic [3:0]  col_select;
    logic [3:0]  key_code;
    logic        key_press;
    logic        key_valid;
    logic        key_ready;
    logic [15:0] key_state;
    logic        overflow;
    logic        overflow_clr;

    logic [15:0] keys;
    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;
    logic [4:0]  exp_q [$];

    keypad_scanner #(
        .SCAN_DIV      (16),
        .DEBOUNCE_SCANS(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rows        (rows),
        .col_select  (col_select),
        .key_code    (key_code),
        .key_press   (key_press),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_state   (key_state),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical matrix: a closed key pulls its row low while its column is strobed.
    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col_select[c] && keys[c*4 + r]) rows[r] = 1'b0;
    end

    always @(posedge clk) if (rst_n) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at edge %0d: got 'h%0h, expected 'h%0h", name, edge_cnt, actual, expected);
        end
    endtask

    task automatic goto_edge(input int target);
        if (target < edge_cnt) begin
            checks++;
            errors++;
            $display("FAIL goto_edge: already at %0d, target %0d", edge_cnt, target);
        end
        while (edge_cnt < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every accepted head entry against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got code 'h%0h press %0b, expected none",
                         key_code, key_press);
            end else begin
                check("event", {27'd0, key_code, key_press}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        key_ready    = 1'b1;
        overflow_clr = 1'b0;
        keys         = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("reset_col", {28'd0, col_select}, 32'hE);
        check("reset_valid", {31'd0, key_valid}, 32'd0);
        check("reset_state", {16'd0, key_state}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        check("reset_code", {28'd0, key_code}, 32'd0);
        rst_n = 1'b1;

        // Column rotation
        goto_edge(15);
        check("col_before_step", {28'd0, col_select}, 32'hE);
        goto_edge(16);
        check("col_step1", {28'd0, col_select}, 32'hD);
        goto_edge(64);
        check("col_wrap", {28'd0, col_select}, 32'hE);

        // Bounce: key 5 held for 3 evaluations only
        keys[5] = 1'b1;
        goto_edge(256);
        keys[5] = 1'b0;
        check("bounce_state_held", {16'd0, key_state}, 32'd0);
        goto_edge(300);
        check("bounce_state_after", {16'd0, key_state}, 32'd0);

        // Press key 5: accepted on the 4th evaluation (edge 546), no early accept
        goto_edge(320);
        keys[5] = 1'b1;
        exp_q.push_back({4'h5, 1'b1});
        goto_edge(545);
        check("press_before_4th", {16'd0, key_state}, 32'd0);
        goto_edge(546);
        check("press_accepted", {16'd0, key_state}, 32'h0020);

        // Release key 5 after holding a few more scans
        goto_edge(704);
        check("press_held", {16'd0, key_state}, 32'h0020);
        keys[5] = 1'b0;
        exp_q.push_back({4'h5, 1'b0});
        goto_edge(929);
        check("release_before_4th", {16'd0, key_state}, 32'h0020);
        goto_edge(930);
        check("release_accepted", {16'd0, key_state}, 32'd0);

        // Backpressure: whole column 2 pressed with the consumer stalled
        goto_edge(960);
        key_ready = 1'b0;
        keys[11:8] = 4'hF;
        exp_q.push_back({4'h8, 1'b1});
        exp_q.push_back({4'h9, 1'b1});
        exp_q.push_back({4'hA, 1'b1});
        exp_q.push_back({4'hB, 1'b1});
        goto_edge(1205);
        check("bp_valid", {31'd0, key_valid}, 32'd1);
        check("bp_head_code", {28'd0, key_code}, 32'h8);
        check("bp_head_press", {31'd0, key_press}, 32'd1);
        check("bp_no_overflow", {31'd0, overflow}, 32'd0);
        check("bp_state", {16'd0, key_state}, 32'h0F00);

        // Release of key 8 hits a full FIFO and is dropped
        goto_edge(1216);
        keys[8] = 1'b0;
        goto_edge(1456);
        check("ovf_before_drop", {31'd0, overflow}, 32'd0);
        goto_edge(1458);
        check("ovf_after_drop", {31'd0, overflow}, 32'd1);
        check("ovf_state", {16'd0, key_state}, 32'h0E00);

        goto_edge(1460);
        key_ready = 1'b1;
        goto_edge(1469);
        check("drain_empty", {31'd0, key_valid}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        overflow_clr = 1'b1;
        goto_edge(1470);
        overflow_clr = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Queue two release events, then reset in the middle of the sweep
        goto_edge(1472);
        key_ready = 1'b0;
        keys[9]   = 1'b0;
        keys[10]  = 1'b0;
        goto_edge(1715);
        check("pre_reset_valid", {31'd0, key_valid}, 32'd1);
        check("pre_reset_state", {16'd0, key_state}, 32'h0800);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, key_valid}, 32'd0);
        check("async_state", {16'd0, key_state}, 32'd0);
        check("async_col", {28'd0, col_select}, 32'hE);
        check("async_overflow", {31'd0, overflow}, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
